// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
//   Shared definitions for the memory-arbiter control blocks: the 2-bit FSM
//   state encoding and the port index constants used to name the winner and
//   the last-served pointer.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } state_t;

  localparam logic PORT0 = 1'b0;  // CPU control path
  localparam logic PORT1 = 1'b1;  // loader

endpackage : mem_arbiter_pkg

// File: rtl/mem_arbiter_rr_pick2.sv
// rr_pick2
//   Two-way round-robin choice, purely combinational.
//   req[1:0] : request vector, bit N = port N
//   last     : port served most recently
//   winner   : chosen port; on a tie the port not served last wins, a single
//              requester always wins. Don't-care when req is 0.
module rr_pick2
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       winner
);

  always_comb begin
    if (req == 2'b11) winner = ~last;
    else              winner = req[1] ? PORT1 : PORT0;
  end

endmodule : rr_pick2

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Two-port round-robin arbiter in front of a synchronous-read memory.
//   One access every two cycles: ACCESS issues the winner's request to the
//   memory (gnt pulse), RESP returns the memory's read data (rvalid pulse).
//   Ports:
//     clk, reset                 rising-edge clock, synchronous active-high reset
//     req0/1, we0/1              request and write flag per port
//     addr0/1, wdata0/1          byte address and write data per port
//     gnt0/1, rvalid0/1          issue and completion pulses per port
//     rdata                      shared read data, 0 unless an rvalid is high
//     mem_en, mem_we             memory enable and write strobe
//     mem_addr, mem_wdata        word-aligned address and write data, 0 when idle
//     mem_rdata                  memory read data, valid one cycle after mem_en
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  // Clears the two byte-offset bits to form a word address.
  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

  state_t state, state_nxt;
  logic   win, win_nxt;     // port owning the access in flight
  logic   last;             // last port that completed an access
  logic   pick_last;
  logic   pick_winner;

  // In RESP the access being completed counts as already served, so a
  // request held through its own RESP loses a tie to the other port.
  assign pick_last = (state == ST_RESP) ? win : last;

  rr_pick2 u_pick (
    .req    ({req1, req0}),
    .last   (pick_last),
    .winner (pick_winner)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      win   <= PORT0;
      last  <= PORT1;   // port 0 wins the first tie
    end else begin
      state <= state_nxt;
      win   <= win_nxt;
      if (state == ST_RESP) last <= win;
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    win_nxt   = win;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    rvalid0   = 1'b0;
    rvalid1   = 1'b0;
    rdata     = '0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;

    case (state)
      ST_ACCESS: begin
        state_nxt = ST_RESP;
        mem_en    = 1'b1;
        // Requesters hold their fields through gnt, so they are driven live
        // rather than captured when the winner was picked.
        if (win == PORT1) begin
          gnt1      = 1'b1;
          mem_we    = we1;
          mem_addr  = addr1 & WORD_MASK;
          mem_wdata = wdata1;
        end else begin
          gnt0      = 1'b1;
          mem_we    = we0;
          mem_addr  = addr0 & WORD_MASK;
          mem_wdata = wdata0;
        end
      end

      ST_IDLE, ST_RESP: begin
        if (state == ST_RESP) begin
          rvalid0 = (win == PORT0);
          rvalid1 = (win == PORT1);
          rdata   = mem_rdata;
        end
        if (req0 || req1) begin
          state_nxt = ST_ACCESS;
          win_nxt   = pick_winner;
        end else begin
          state_nxt = ST_IDLE;
        end
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule : mem_arbiter

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, the address width of every port.
REQ-002 The block SHALL have parameter DATA_W, default 32, the data width of every port.
REQ-003 The block SHALL have one clock, clk, and reset is synchronous and active-high on port reset.
REQ-004 The block SHALL have the port clk, input, 1 bit: the single rising-edge clock.
REQ-005 The block SHALL have the port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have the ports req0/req1, input, 1 bit each: access request from port 0 (CPU control path) and port 1 (loader).
REQ-007 The block SHALL have the ports we0/we1, input, 1 bit each: 1 = write, 0 = read.
REQ-008 The block SHALL have the ports addr0/addr1, input, ADDR_W each: byte address.
REQ-009 The block SHALL have the ports wdata0/wdata1, input, DATA_W each: write data.
REQ-010 The block SHALL have the ports gnt0/gnt1, output, 1 bit each: one-cycle pulse when the port's access is issued.
REQ-011 The block SHALL have the ports rvalid0/rvalid1, output, 1 bit each: one-cycle completion pulse, for reads and writes.
REQ-012 The block SHALL have the port rdata, output, DATA_W: read data, shared by both ports, valid only while rvalid0 or rvalid1 is high.
REQ-013 The block SHALL have the ports mem_en/mem_we, output, 1 bit each: memory enable and write strobe.
REQ-014 The block SHALL have the ports mem_addr/mem_wdata, output, ADDR_W/DATA_W: memory address and write data.
REQ-015 The block SHALL have the port mem_rdata, input, DATA_W: synchronous-read memory output, valid one cycle after mem_en.

Function
REQ-016 The FSM SHALL have the states IDLE, ACCESS and RESP.
REQ-017 In IDLE or RESP, if any reqN is high, the block SHALL pick a winner, register it, and go to ACCESS next cycle; otherwise it SHALL go to IDLE.
REQ-018 Arbitration SHALL be round-robin: when both ports request, the port not served last wins; a single requester always wins.
REQ-019 In ACCESS, the block SHALL drive mem_en=1, mem_we=weW, mem_addr={addrW[ADDR_W-1:2],2'b00} and mem_wdata=wdataW, where W is the winner; gntW SHALL be 1 for exactly this cycle.
REQ-020 In ACCESS, the next state SHALL always be RESP.
REQ-021 In RESP, rvalidW SHALL be 1 for exactly one cycle, rdata SHALL equal mem_rdata, and the last-served pointer SHALL update to W.
REQ-022 Latency SHALL be 2 cycles from req sampled to rvalid, and the sustained throughput SHALL be one access per 2 cycles.
REQ-023 Requesters SHALL hold req, we, addr and wdata stable until their gnt cycle inclusive; the block SHALL not latch them earlier.
REQ-024 A req deasserted before its gnt SHALL be dropped with no memory access.
REQ-025 Outside ACCESS, mem_en, mem_we and both gnt outputs SHALL be 0; mem_addr and mem_wdata SHALL be 0 outside ACCESS.
REQ-026 At most one of gnt0/gnt1, and at most one of rvalid0/rvalid1, SHALL be high in any cycle.
REQ-027 A req held high through RESP of its own access SHALL be treated as a new request, and round-robin SHALL still apply.
REQ-028 rdata SHALL be 0 when neither rvalid output is high.

Reset
REQ-029 While reset is high at a clock edge, the state SHALL become IDLE, the last-served pointer SHALL become port 1 (so port 0 wins the first tie), and all outputs SHALL be 0 in the following cycle.
REQ-030 A reset asserted in ACCESS or RESP SHALL abandon the access with no rvalid; a write already issued in ACCESS is not undone.

Structure
REQ-031 The state encoding (2 bits) and the port index constants SHALL live in the shared package used by the other control blocks.
REQ-032 The round-robin choice SHALL be the sub-module rr_pick2, with inputs req[1:0] and last and output winner, combinational.

Verification
REQ-033 The bench SHALL cover: reset, then req0 read addr0=0x10 with mem holding 0xDEADBEEF -> gnt0 at cycle 1, rvalid0 at cycle 2 with rdata=0xDEADBEEF.
REQ-034 The bench SHALL cover: req0 and req1 both held high from reset -> grant order 0,1,0,1 with gnt pulses 2 cycles apart.
REQ-035 The bench SHALL cover: req1 write addr1=0x22, wdata1=0x12345678 -> in the gnt1 cycle, mem_we=1, mem_addr=0x20, mem_wdata=0x12345678; rvalid1 next cycle.
REQ-036 The bench SHALL cover: reset pulsed in the ACCESS cycle -> no rvalid, state IDLE, and the next tie goes to port 0.
REQ-037 The bench SHALL cover: req1 dropped while port 0 is served -> port 1 never gets gnt1 and mem_en is never high for addr1.
